// File: rtl/truth_table_sweeper_pkg.sv
// Shared types for the truth-table sweeper: FSM state encodings and timer width.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DWELL_W = 8;

endpackage

// File: rtl/truth_table_sweeper_dwell_timer.sv
// Dwell counter: counts cycles while tick is high and flags the final cycle (count == DWELL-1).
module truth_table_sweeper_dwell_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic last
);

  localparam logic [DWELL_W-1:0] LAST_CNT = DWELL_W'(DWELL - 1);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  assign last = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      // Wraps on its own so the next input code starts a fresh dwell.
      cnt_d = last ? '0 : cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input code of a small combinational block, captures f into a truth table
// and compares it against a golden table, reporting match and the lowest failing row.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; x and results hold their last values
//   ST_DRIVE | applying code x, sampling f on the final dwell cycle
//   ST_DONE  | one-cycle done pulse; match/mismatch_idx just updated
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                 N_IN     = 3,
  parameter int                 DWELL    = 4,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'hE8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               f,
  output logic [N_IN-1:0]    x,
  output logic               busy,
  output logic               done,
  output logic [2**N_IN-1:0] tt,
  output logic               match,
  output logic [N_IN-1:0]    mismatch_idx
);

  localparam int              TT_W   = 2**N_IN;
  localparam logic [N_IN-1:0] X_LAST = '1;

  state_e            state_q;
  logic [N_IN-1:0]   x_q;
  logic              busy_q;
  logic              done_q;
  logic [TT_W-1:0]   tt_q;
  logic              match_q;
  logic [N_IN-1:0]   idx_q;

  logic [TT_W-1:0]   tt_d;
  logic [TT_W-1:0]   diff_d;
  logic [N_IN-1:0]   idx_d;
  logic              dwell_last;

  truth_table_sweeper_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == ST_IDLE),
    .tick  (state_q == ST_DRIVE),
    .last  (dwell_last)
  );

  // Table including the bit sampled this cycle, so the final row is part of the compare.
  always_comb begin
    tt_d       = tt_q;
    tt_d[x_q]  = f;
  end

  always_comb begin
    diff_d = tt_d ^ EXPECTED;
    idx_d  = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (diff_d[i]) idx_d = N_IN'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      match_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_DRIVE;
            x_q     <= '0;
            busy_q  <= 1'b1;
            tt_q    <= '0;
            match_q <= 1'b0;
            idx_q   <= '0;
          end
        end
        ST_DRIVE: begin
          if (dwell_last) begin
            tt_q <= tt_d;
            if (x_q == X_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              match_q <= (tt_d == EXPECTED);
              idx_q   <= idx_d;
            end else begin
              x_q <= x_q + N_IN'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign x            = x_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tt           = tt_q;
  assign match        = match_q;
  assign mismatch_idx = idx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two sweepers (DWELL=4 and DWELL=1) driving a behavioural majority/xor block.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       start0, start1;
  logic       use_xor;
  logic       f0, f1;
  logic [2:0] x0, x1;
  logic       busy0, busy1, done0, done1, match0, match1;
  logic [7:0] tt0, tt1;
  logic [2:0] idx0, idx1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic blk(input logic [2:0] xv, input logic sel_xor);
    if (sel_xor) return ^xv;
    return (xv[2] & xv[1]) | (xv[2] & xv[0]) | (xv[1] & xv[0]);
  endfunction

  assign f0 = blk(x0, use_xor);
  assign f1 = blk(x1, 1'b0);

  truth_table_sweeper #(.N_IN(3), .DWELL(4), .EXPECTED(8'hE8)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .f(f0), .x(x0), .busy(busy0),
    .done(done0), .tt(tt0), .match(match0), .mismatch_idx(idx0)
  );

  truth_table_sweeper #(.N_IN(3), .DWELL(1), .EXPECTED(8'hE8)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .f(f1), .x(x1), .busy(busy1),
    .done(done1), .tt(tt1), .match(match1), .mismatch_idx(idx1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One start pulse, then per-cycle checks of x stepping and done timing (done at n=33).
  task automatic sweep0(input logic [7:0] ett, input logic em, input logic [2:0] eidx);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      if (n > 1) tick();
      if (n <= 32) begin
        check("x_step", x0, (n - 1) / 4);
        check("done_early", done0, 0);
      end
    end
    check("done_pulse", done0, 1);
    check("busy_in_done", busy0, 0);
    check("x_final", x0, 7);
    check("tt_final", tt0, ett);
    check("match_final", match0, em);
    check("idx_final", idx0, eidx);
    tick();
    check("done_one_cycle", done0, 0);
    check("x_held", x0, 7);
    check("tt_held", tt0, ett);
    check("match_held", match0, em);
  endtask

  initial begin
    int cnt;
    int first;
    reset   = 1'b1;
    start0  = 1'b0;
    start1  = 1'b0;
    use_xor = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_x", x0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_tt", tt0, 0);
    check("rst_match", match0, 0);
    check("rst_idx", idx0, 0);
    tick();

    // Majority block, matches golden table.
    sweep0(8'hE8, 1'b1, 3'd0);

    // XOR block against majority golden: E8^96 = 7E, lowest set bit 1.
    use_xor = 1'b1;
    tick();
    sweep0(8'h96, 1'b0, 3'd1);
    use_xor = 1'b0;

    // Reset while x=5: codes 0..4 sampled, only code 3 is 1 -> tt=08.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("start_clears_match", match0, 0);
    check("start_clears_idx", idx0, 0);
    repeat (20) tick();
    check("mid_x", x0, 5);
    check("mid_tt", tt0, 8'h08);
    check("mid_busy", busy0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_x", x0, 0);
    check("abort_busy", busy0, 0);
    check("abort_tt", tt0, 0);
    check("abort_done", done0, 0);
    tick();
    sweep0(8'hE8, 1'b1, 3'd0);

    // start held for 10 cycles: exactly one sweep and one done pulse.
    start0 = 1'b1;
    cnt    = 0;
    first  = 0;
    for (int n = 1; n <= 50; n++) begin
      tick();
      if (n == 10) start0 = 1'b0;
      if (done0) begin
        cnt++;
        if (first == 0) first = n;
      end
    end
    check("held_start_dones", cnt, 1);
    check("held_start_done_cycle", first, 33);
    check("held_start_busy", busy0, 0);
    check("held_start_tt", tt0, 8'hE8);

    // DWELL=1: x changes every cycle, done at n=9.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      if (n > 1) tick();
      if (n <= 8) begin
        check("d1_x_step", x1, n - 1);
        check("d1_done_early", done1, 0);
      end
    end
    check("d1_done", done1, 1);
    check("d1_tt", tt1, 8'hE8);
    check("d1_match", match1, 1);
    check("d1_idx", idx1, 0);

    // Back-to-back: start during done is ignored, start the cycle after is taken.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (32) tick();
    check("b2b_done1", done0, 1);
    check("b2b_tt1", tt0, 8'hE8);
    start0 = 1'b1;
    tick();
    check("b2b_ignored_in_done", busy0, 0);
    check("b2b_idle_x_held", x0, 7);
    tick();
    start0 = 1'b0;
    check("b2b_busy", busy0, 1);
    check("b2b_tt_cleared", tt0, 0);
    check("b2b_x_restart", x0, 0);
    repeat (32) tick();
    check("b2b_done2", done0, 1);
    check("b2b_tt2", tt0, 8'hE8);
    check("b2b_match2", match0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
